ula_multiciclo: RTL and testbench

Parametrised multi-cycle successor to the processor's combinational ALU. It keeps the same 5-bit `ulaOP` encoding and the `saidaULA`/`saidaHI`/`saidaLO` outputs. Multiply, divide and remainder run on an iterative shift-add / restoring-division datapath over `WIDTH` cycles, so the control unit stalls on `ocupado` and advances on `pronto`. All other operations complete in one cycle. HI/LO are architectural registers held inside the block.

---
 rtl/ula_pkg.sv | 33 +++
 rtl/ula_muldiv_iter.sv | 90 +++++++++
 rtl/ula_multiciclo.sv | 158 +++++++++++++++
 tb/tb_ula_multiciclo.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// ula_pkg: shared definitions for the multi-cycle ALU.
//   - 5-bit opcode constants (same encoding as the former combinational ALU)
//   - FSM state type for the top-level controller
//   - is_iterativa(): tells whether an opcode uses the shift/subtract datapath
package ula_pkg;

  localparam logic [4:0] soma          = 5'b00000;
  localparam logic [4:0] subtracao     = 5'b00001;
  localparam logic [4:0] multiplicacao = 5'b00010;
  localparam logic [4:0] divisao       = 5'b00011;
  localparam logic [4:0] restoDivisao  = 5'b00100;
  localparam logic [4:0] OPor          = 5'b00101;
  localparam logic [4:0] OPand         = 5'b00110;
  localparam logic [4:0] OPnot         = 5'b00111;
  localparam logic [4:0] OPxor         = 5'b01000;
  localparam logic [4:0] OPnor         = 5'b01001;
  localparam logic [4:0] OPnand        = 5'b01010;
  localparam logic [4:0] OPxnor        = 5'b01011;
  localparam logic [4:0] maior         = 5'b01110;
  localparam logic [4:0] seguidor      = 5'b11111;

  // Explicit encodings so the debug state output is stable across tools.
  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    CALC   = 2'd1,
    FIM    = 2'd2
  } estado_t;

  function automatic logic is_iterativa(input logic [4:0] op);
    return (op == multiplicacao) || (op == divisao) || (op == restoDivisao);
  endfunction

endpackage

// File: rtl/ula_muldiv_iter.sv
// ula_muldiv_iter: iterative unsigned multiply / restoring divide datapath.
// One partial product (mul) or one quotient bit (div) per clock edge.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   start        : load operands and clear the counter (a, b, modo sampled)
//   modo         : 0 = multiply, 1 = divide
//   a, b         : operands (mul: a*b ; div: a / b)
//   hi, lo       : result of the step taken at the coming edge;
//                  meaningful when done=1 (mul: product high/low,
//                  div: remainder/quotient)
//   done         : the coming edge performs the final (WIDTH-th) step
module ula_muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             modo,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done
);

  logic             busy_q;
  logic             modo_q;
  logic [CNT_W-1:0] cnt_q;
  // Multiplicand (mul) or divisor (div): the value added/subtracted each step.
  logic [WIDTH-1:0] oper_q;
  // hi_q/lo_q: running product {hi,lo} for mul, {remainder, dividend->quotient} for div.
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic [WIDTH-1:0] hi_step;
  logic [WIDTH-1:0] lo_step;
  logic [WIDTH:0]   soma_w;
  logic [WIDTH:0]   desloc_w;
  logic [WIDTH:0]   dif_w;

  always_comb begin
    // Shift-add: add multiplicand when the current multiplier LSB is 1,
    // then shift the whole {carry, hi, lo} right by one.
    soma_w   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, oper_q} : '0);
    // Restoring step: bring in the next dividend bit and try to subtract.
    desloc_w = {hi_q, lo_q[WIDTH-1]};
    dif_w    = desloc_w - {1'b0, oper_q};
    if (!modo_q) begin
      hi_step = soma_w[WIDTH:1];
      lo_step = {soma_w[0], lo_q[WIDTH-1:1]};
    end else if (!dif_w[WIDTH]) begin
      // No borrow: subtraction fits, quotient bit is 1.
      hi_step = dif_w[WIDTH-1:0];
      lo_step = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      hi_step = desloc_w[WIDTH-1:0];
      lo_step = {lo_q[WIDTH-2:0], 1'b0};
    end
  end

  assign hi   = hi_step;
  assign lo   = lo_step;
  assign done = busy_q && (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= 1'b0;
      modo_q <= 1'b0;
      cnt_q  <= '0;
      oper_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      modo_q <= modo;
      cnt_q  <= '0;
      oper_q <= modo ? b : a;
      hi_q   <= '0;
      lo_q   <= modo ? a : b;
    end else if (busy_q) begin
      hi_q  <= hi_step;
      lo_q  <= lo_step;
      cnt_q <= cnt_q + CNT_W'(1);
      if (done) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ula_multiciclo.sv
// ula_multiciclo: multi-cycle ALU with architectural HI/LO registers.
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   inicio, ulaOP       : start strobe and opcode (accepted while ocupado=0)
//   RS, RT              : operands, sampled with inicio
//   saidaULA            : result register
//   saidaHI, saidaLO    : HI/LO registers (written by mul/div/rem only)
//   ocupado             : iterative operation in progress
//   pronto              : one-cycle pulse, result valid this cycle
//   divZero             : last accepted op was div/rem with RT=0
//   estado              : current FSM state (debug visibility)
// Handshake: an op is accepted on a rising edge where inicio=1 and ocupado=0;
// its result is presented in the cycle where pronto=1. inicio while ocupado=1
// is dropped, not queued.
module ula_multiciclo
  import ula_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inicio,
  input  logic [4:0]       ulaOP,
  input  logic [WIDTH-1:0] RS,
  input  logic [WIDTH-1:0] RT,
  output logic [WIDTH-1:0] saidaULA,
  output logic [WIDTH-1:0] saidaHI,
  output logic [WIDTH-1:0] saidaLO,
  output logic             ocupado,
  output logic             pronto,
  output logic             divZero,
  output logic [1:0]       estado
);

  estado_t          estado_q, estado_d;
  logic [WIDTH-1:0] ula_q, ula_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             pronto_q, pronto_d;
  logic             dz_q, dz_d;
  logic [4:0]       op_q, op_d;

  logic             iter_start;
  logic             iter_done;
  logic [WIDTH-1:0] iter_hi;
  logic [WIDTH-1:0] iter_lo;
  logic [WIDTH-1:0] alu_res;
  logic             eh_div;

  assign eh_div = (ulaOP == divisao) || (ulaOP == restoDivisao);

  // Single-cycle operations.
  always_comb begin
    alu_res = '0;
    case (ulaOP)
      soma:      alu_res = RS + RT;
      subtracao: alu_res = RS - RT;
      OPor:      alu_res = RS | RT;
      OPand:     alu_res = RS & RT;
      OPnot:     alu_res = ~RS;
      OPxor:     alu_res = RS ^ RT;
      OPnor:     alu_res = ~(RS | RT);
      OPnand:    alu_res = ~(RS & RT);
      OPxnor:    alu_res = ~(RS ^ RT);
      maior:     alu_res = {{(WIDTH-1){1'b0}}, (RS > RT)};
      seguidor:  alu_res = RT;
      default:   alu_res = '0;
    endcase
  end

  always_comb begin
    estado_d   = estado_q;
    ula_d      = ula_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    pronto_d   = 1'b0;
    dz_d       = dz_q;
    op_d       = op_q;
    iter_start = 1'b0;
    case (estado_q)
      CALC: begin
        if (iter_done) begin
          ula_d    = (op_q == restoDivisao) ? iter_hi : iter_lo;
          hi_d     = iter_hi;
          lo_d     = iter_lo;
          pronto_d = 1'b1;
          estado_d = FIM;
        end
      end
      default: begin
        // OCIOSO and FIM behave identically: FIM just carries the pronto pulse.
        estado_d = OCIOSO;
        if (inicio) begin
          dz_d = 1'b0;
          op_d = ulaOP;
          if (is_iterativa(ulaOP) && !(eh_div && (RT == '0))) begin
            iter_start = 1'b1;
            estado_d   = CALC;
          end else if (eh_div) begin
            // Division by zero completes immediately with a defined result.
            lo_d     = '1;
            hi_d     = RS;
            ula_d    = (ulaOP == divisao) ? '1 : RS;
            dz_d     = 1'b1;
            pronto_d = 1'b1;
          end else begin
            ula_d    = alu_res;
            pronto_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= OCIOSO;
      ula_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      pronto_q <= 1'b0;
      dz_q     <= 1'b0;
      op_q     <= '0;
    end else begin
      estado_q <= estado_d;
      ula_q    <= ula_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      pronto_q <= pronto_d;
      dz_q     <= dz_d;
      op_q     <= op_d;
    end
  end

  ula_muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clock (clock),
    .reset (reset),
    .start (iter_start),
    .modo  (ulaOP != multiplicacao),
    .a     (RS),
    .b     (RT),
    .hi    (iter_hi),
    .lo    (iter_lo),
    .done  (iter_done)
  );

  assign saidaULA = ula_q;
  assign saidaHI  = hi_q;
  assign saidaLO  = lo_q;
  assign ocupado  = (estado_q == CALC);
  assign pronto   = pronto_q;
  assign divZero  = dz_q;
  assign estado   = estado_q;

endmodule

// File: tb/tb_ula_multiciclo.sv
// Bench for ula_multiciclo: a transaction-level model of the 32-bit instance
// checked every cycle, directed vectors with literal expectations, and a
// few literal checks on an 8-bit instance.
module tb_ula_multiciclo;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT (WIDTH=32) ----------------
  logic        inicio = 1'b0;
  logic [4:0]  ulaOP = '0;
  logic [31:0] RS = '0, RT = '0;
  logic [31:0] saidaULA, saidaHI, saidaLO;
  logic        ocupado, pronto, divZero;
  logic [1:0]  estado;

  ula_multiciclo #(.WIDTH(32)) u32 (
    .clock(clk), .reset(reset), .inicio(inicio), .ulaOP(ulaOP), .RS(RS), .RT(RT),
    .saidaULA(saidaULA), .saidaHI(saidaHI), .saidaLO(saidaLO),
    .ocupado(ocupado), .pronto(pronto), .divZero(divZero), .estado(estado)
  );

  // ---------------- DUT (WIDTH=8) ----------------
  logic       inicio8 = 1'b0;
  logic [4:0] op8 = '0;
  logic [7:0] rs8 = '0, rt8 = '0;
  logic [7:0] ula8, hi8, lo8;
  logic       ocup8, pronto8, dz8;
  logic [1:0] estado8;

  ula_multiciclo #(.WIDTH(8)) u8 (
    .clock(clk), .reset(reset), .inicio(inicio8), .ulaOP(op8), .RS(rs8), .RT(rt8),
    .saidaULA(ula8), .saidaHI(hi8), .saidaLO(lo8),
    .ocupado(ocup8), .pronto(pronto8), .divZero(dz8), .estado(estado8)
  );

  // ---------------- check bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  logic check_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (32-bit instance) ----------------
  typedef struct packed {
    logic [31:0] ula;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        wr_hilo;
    logic        dz;
    logic        iter;
  } res_t;

  function automatic res_t compute(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    res_t r;
    logic [63:0] p;
    r = '0;
    case (op)
      5'b00000: r.ula = a + b;
      5'b00001: r.ula = a - b;
      5'b00010: begin
        p = {32'd0, a} * {32'd0, b};
        r.hi = p[63:32]; r.lo = p[31:0]; r.ula = p[31:0];
        r.wr_hilo = 1'b1; r.iter = 1'b1;
      end
      5'b00011, 5'b00100: begin
        r.wr_hilo = 1'b1;
        if (b == 0) begin
          r.lo = 32'hFFFF_FFFF; r.hi = a; r.dz = 1'b1;
          r.ula = (op == 5'b00011) ? 32'hFFFF_FFFF : a;
        end else begin
          r.lo = a / b; r.hi = a % b; r.iter = 1'b1;
          r.ula = (op == 5'b00011) ? a / b : a % b;
        end
      end
      5'b00101: r.ula = a | b;
      5'b00110: r.ula = a & b;
      5'b00111: r.ula = ~a;
      5'b01000: r.ula = a ^ b;
      5'b01001: r.ula = ~(a | b);
      5'b01010: r.ula = ~(a & b);
      5'b01011: r.ula = ~(a ^ b);
      5'b01110: r.ula = (a > b) ? 32'd1 : 32'd0;
      5'b11111: r.ula = b;
      default:  r.ula = 32'd0;
    endcase
    return r;
  endfunction

  res_t        r_now, m_pend;
  logic [31:0] m_ula = '0, m_hi = '0, m_lo = '0;
  logic        m_pronto = 1'b0, m_dz = 1'b0;
  int          m_cnt = 0;   // cycles left until an iterative result lands

  assign r_now = compute(ulaOP, RS, RT);

  always @(posedge clk) begin
    if (reset) begin
      m_ula <= '0; m_hi <= '0; m_lo <= '0;
      m_pronto <= 1'b0; m_dz <= 1'b0; m_cnt <= 0;
    end else begin
      m_pronto <= 1'b0;
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_ula <= m_pend.ula; m_hi <= m_pend.hi; m_lo <= m_pend.lo;
          m_pronto <= 1'b1;
        end
      end else if (inicio) begin
        m_dz <= r_now.dz;
        if (r_now.iter) begin
          m_cnt  <= 32;
          m_pend <= r_now;
        end else begin
          m_ula <= r_now.ula;
          if (r_now.wr_hilo) begin
            m_hi <= r_now.hi; m_lo <= r_now.lo;
          end
          m_pronto <= 1'b1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (check_en) begin
      chk("cyc_ula",     {32'd0, saidaULA}, {32'd0, m_ula});
      chk("cyc_hi",      {32'd0, saidaHI},  {32'd0, m_hi});
      chk("cyc_lo",      {32'd0, saidaLO},  {32'd0, m_lo});
      chk("cyc_pronto",  {63'd0, pronto},   {63'd0, m_pronto});
      chk("cyc_ocupado", {63'd0, ocupado},  {63'd0, (m_cnt != 0)});
      chk("cyc_divzero", {63'd0, divZero},  {63'd0, m_dz});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    ulaOP = op; RS = a; RT = b; inicio = 1'b1;
    tick();
    inicio = 1'b0;
  endtask

  task automatic issue8(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
    op8 = op; rs8 = a; rt8 = b; inicio8 = 1'b1;
    tick();
    inicio8 = 1'b0;
  endtask

  // Bounded wait for pronto; the cycle count is itself checked.
  task automatic wait_pronto(input string nm, input bit sel8, input int exp_n);
    int n;
    n = 0;
    while (!(sel8 ? pronto8 : pronto) && n < 200) begin
      tick();
      n++;
    end
    chk(nm, 64'(n), 64'(exp_n));
  endtask

  // ---------------- directed single-cycle vectors ----------------
  logic [4:0]  t_op [12] = '{5'b00001, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001,
                             5'b01010, 5'b01011, 5'b01110, 5'b01110, 5'b11111, 5'b01100};
  logic [31:0] t_a  [12] = '{32'h0, 32'hF0F00000, 32'hFF00FF00, 32'h0000FFFF, 32'hAAAA5555, 32'h0F0F0F0F,
                             32'hFFFFFFFF, 32'h12345678, 32'h80000000, 32'h5, 32'h1, 32'h12345678};
  logic [31:0] t_b  [12] = '{32'h1, 32'h0000F0F0, 32'h0FF00FF0, 32'h0, 32'hFFFF0000, 32'hF0F00000,
                             32'h0000FFFF, 32'h12345678, 32'h7FFFFFFF, 32'h5, 32'hDEADBEEF, 32'h1};
  logic [31:0] t_e  [12] = '{32'hFFFFFFFF, 32'hF0F0F0F0, 32'h0F000F00, 32'hFFFF0000, 32'h55555555, 32'h0000F0F0,
                             32'hFFFF0000, 32'hFFFFFFFF, 32'h1, 32'h0, 32'hDEADBEEF, 32'h0};

  // ---------------- main sequence ----------------
  initial begin
    tick();
    tick();
    check_en = 1'b1;
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_ula",    {32'd0, saidaULA}, 64'd0);
    chk("rst_hi",     {32'd0, saidaHI},  64'd0);
    chk("rst_lo",     {32'd0, saidaLO},  64'd0);
    chk("rst_pronto", {63'd0, pronto},   64'd0);
    chk("rst_estado", {62'd0, estado},   64'd0);

    // soma wraps
    issue(5'b00000, 32'hFFFFFFFF, 32'h2);
    chk("soma_ula",    {32'd0, saidaULA}, 64'h1);
    chk("soma_pronto", {63'd0, pronto},   64'h1);
    chk("soma_hi",     {32'd0, saidaHI},  64'h0);

    // multiply 0x10000 * 0x30000
    issue(5'b00010, 32'h00010000, 32'h00030000);
    chk("mul_ocupado", {63'd0, ocupado}, 64'h1);
    wait_pronto("mul_latency", 1'b0, 32);
    chk("mul_hi",      {32'd0, saidaHI},  64'h3);
    chk("mul_lo",      {32'd0, saidaLO},  64'h0);
    chk("mul_ula",     {32'd0, saidaULA}, 64'h0);
    chk("mul_model_hi",{32'd0, m_hi},     64'h3);
    tick();
    chk("mul_pulse",   {63'd0, pronto},   64'h0);

    // divisao 100/7 then restoDivisao back-to-back in FIM
    issue(5'b00011, 32'd100, 32'd7);
    wait_pronto("div_latency", 1'b0, 32);
    chk("div_ula", {32'd0, saidaULA}, 64'd14);
    chk("div_lo",  {32'd0, saidaLO},  64'd14);
    chk("div_hi",  {32'd0, saidaHI},  64'd2);
    issue(5'b00100, 32'd100, 32'd7);
    chk("rem_b2b_ocupado", {63'd0, ocupado}, 64'h1);
    wait_pronto("rem_latency", 1'b0, 32);
    chk("rem_ula", {32'd0, saidaULA}, 64'd2);
    chk("rem_hi",  {32'd0, saidaHI},  64'd2);
    chk("rem_lo",  {32'd0, saidaLO},  64'd14);

    // divide by zero
    issue(5'b00011, 32'h1234, 32'h0);
    chk("dz_pronto", {63'd0, pronto},   64'h1);
    chk("dz_ula",    {32'd0, saidaULA}, 64'hFFFFFFFF);
    chk("dz_hi",     {32'd0, saidaHI},  64'h1234);
    chk("dz_lo",     {32'd0, saidaLO},  64'hFFFFFFFF);
    chk("dz_flag",   {63'd0, divZero},  64'h1);
    issue(5'b00000, 32'h1, 32'h1);
    chk("dz_clear",  {63'd0, divZero},  64'h0);
    chk("dz_hi_kept",{32'd0, saidaHI},  64'h1234);
    issue(5'b00100, 32'h55, 32'h0);
    chk("rz_ula",    {32'd0, saidaULA}, 64'h55);

    // single-cycle table
    for (int i = 0; i < 12; i++) begin
      issue(t_op[i], t_a[i], t_b[i]);
      chk($sformatf("tab%0d_ula", i), {32'd0, saidaULA}, {32'd0, t_e[i]});
      chk($sformatf("tab%0d_pronto", i), {63'd0, pronto}, 64'h1);
    end

    // full-range multiply, then a soma accepted in FIM
    issue(5'b00010, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_pronto("mulmax_latency", 1'b0, 32);
    chk("mulmax_hi", {32'd0, saidaHI}, 64'hFFFFFFFE);
    chk("mulmax_lo", {32'd0, saidaLO}, 64'h1);
    issue(5'b00000, 32'd2, 32'd3);
    chk("fim_soma_ula",    {32'd0, saidaULA}, 64'd5);
    chk("fim_soma_pronto", {63'd0, pronto},   64'h1);

    // remainder with large dividend
    issue(5'b00100, 32'hFFFFFFFF, 32'h10);
    wait_pronto("remmax_latency", 1'b0, 32);
    chk("remmax_ula", {32'd0, saidaULA}, 64'hF);
    chk("remmax_lo",  {32'd0, saidaLO},  64'h0FFFFFFF);

    // inicio while busy ignored; reset during iteration 10 aborts
    issue(5'b00000, 32'd1, 32'd1);
    issue(5'b00010, 32'd5, 32'd7);
    tick(); tick(); tick();
    issue(5'b00110, 32'hF0F0, 32'h00FF);
    chk("busy_ignore_ocupado", {63'd0, ocupado},   64'h1);
    chk("busy_ignore_ula",     {32'd0, saidaULA},  64'd2);
    tick(); tick(); tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_ula",    {32'd0, saidaULA}, 64'h0);
    chk("abort_hi",     {32'd0, saidaHI},  64'h0);
    chk("abort_lo",     {32'd0, saidaLO},  64'h0);
    chk("abort_ocup",   {63'd0, ocupado},  64'h0);
    chk("abort_estado", {62'd0, estado},   64'h0);
    tick();
    chk("abort_no_pronto", {63'd0, pronto}, 64'h0);

    // 8-bit instance
    issue8(5'b01110, 8'h80, 8'h7F);
    chk("w8_maior",  {56'd0, ula8},     64'h1);
    chk("w8_pronto", {63'd0, pronto8},  64'h1);
    issue8(5'b00010, 8'hFF, 8'hFF);
    chk("w8_ocupado", {63'd0, ocup8}, 64'h1);
    wait_pronto("w8_mul_latency", 1'b1, 8);
    chk("w8_mul_hi",  {56'd0, hi8},  64'hFE);
    chk("w8_mul_lo",  {56'd0, lo8},  64'h01);
    chk("w8_mul_ula", {56'd0, ula8}, 64'h01);
    issue8(5'b00011, 8'd200, 8'd9);
    wait_pronto("w8_div_latency", 1'b1, 8);
    chk("w8_div_lo", {56'd0, lo8}, 64'd22);
    chk("w8_div_hi", {56'd0, hi8}, 64'd2);

    tick();
    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
